// File: rtl/enc_pkg.sv
// Shared constants for the event encoder.
//   N_DEFAULT : default number of request lines
//   N_MAX     : largest supported number of request lines
//   idx_w()   : width of a binary index able to name any of n lines
package enc_pkg;

  localparam int N_DEFAULT = 4;
  localparam int N_MAX     = 16;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/enc_pick.sv
// Combinational selector: finds the first set bit of pend, starting the
// search at index start and wrapping around modulo N.
//   HIGH_FIRST = 1 : search walks downward (start, start-1, ...)
//   HIGH_FIRST = 0 : search walks upward   (start, start+1, ...)
// Ports:
//   pend  [N-1:0] : candidate vector
//   start [W-1:0] : first index examined
//   found         : some bit of pend is set
//   idx   [W-1:0] : selected index (0 when nothing found)
module enc_pick
  import enc_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int W          = idx_w(N),
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [N-1:0] pend,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      if (HIGH_FIRST) j = (int'(start) - k + N) % N;
      else            j = (int'(start) + k) % N;
      if (!found && pend[j[W-1:0]]) begin
        found = 1'b1;
        idx   = j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/event_encoder.sv
// Event encoder: collects one-cycle event pulses on req into a pending
// vector and emits their binary indices one at a time over a valid/ready
// output slot.
// Build option: define EVENT_ENCODER_ROUND_ROBIN_EN for round-robin
// selection (search from last loaded index + 1, upward with wrap);
// otherwise the highest pending index wins.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : capture enable for req (queued events drain anyway)
//   req   [N-1:0]   : event pulses
//   code_valid      : code holds an emitted index
//   code_ready      : consumer accepts code on valid & ready
//   code  [W-1:0]   : emitted index (0 when not valid)
//   pending [N-1:0] : captured, not yet emitted events
//   drop_err        : sticky, an event coalesced into an already pending one
module event_encoder
  import enc_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic         code_valid,
  input  logic         code_ready,
  output logic [W-1:0] code,
  output logic [N-1:0] pending,
  output logic         drop_err
);

  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] code_q, code_d;
  logic         code_valid_q, code_valid_d;
  logic         drop_err_q, drop_err_d;

  logic         pick_found;
  logic [W-1:0] pick_idx;
  logic [W-1:0] pick_start;

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Search begins one past the last loaded index, wrapping at N-1.
  assign pick_start = (ptr_q == W'(N - 1)) ? '0 : ptr_q + 1'b1;

  enc_pick #(.N(N), .W(W), .HIGH_FIRST(1'b0)) u_pick (
    .pend  (pending_q),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );
`else
  assign pick_start = W'(N - 1);

  enc_pick #(.N(N), .W(W), .HIGH_FIRST(1'b1)) u_pick (
    .pend  (pending_q),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );
`endif

  logic         slot_free;
  logic         load;
  logic [N-1:0] clr_mask;
  logic [N-1:0] set_mask;

  always_comb begin
    slot_free = !code_valid_q || code_ready;
    load      = slot_free && pick_found;
    clr_mask  = load ? ({{(N-1){1'b0}}, 1'b1} << pick_idx) : '0;
    set_mask  = en ? req : '0;

    // Setting wins over clearing so an event arriving as its index loads
    // is re-queued instead of lost.
    pending_d  = (pending_q & ~clr_mask) | set_mask;

    // A new pulse on a bit that stays pending merges into it: that event is lost.
    drop_err_d = drop_err_q | (|(set_mask & pending_q & ~clr_mask));

    code_d       = code_q;
    code_valid_d = code_valid_q;
    if (slot_free) begin
      code_valid_d = load;
      code_d       = load ? pick_idx : '0;
    end
  end

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = load ? pick_idx : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= W'(N - 1);
    else     ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign code_valid = code_valid_q;
  assign code       = code_q;
  assign pending    = pending_q;
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_event_encoder.sv
// Bench for event_encoder (N=4): directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the
// pending set, output slot and sticky drop flag. Honours
// EVENT_ENCODER_ROUND_ROBIN_EN the same way the design does.
module tb_event_encoder;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       code_valid;
  logic       code_ready;
  logic [1:0] code;
  logic [3:0] pending;
  logic       drop_err;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  // Reference state
  int m_pend;
  bit m_valid;
  int m_code;
  bit m_drop;
  int m_ptr;

  event_encoder #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code       (code),
    .pending    (pending),
    .drop_err   (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  // One clock edge of the behavioural model, applied to the inputs the DUT saw.
  task automatic model_edge(input bit e, input int r, input bit rdy, input bit rs);
    bit found;
    int idx;
    bit free_s;
    if (rs) begin
      m_pend = 0; m_valid = 0; m_code = 0; m_drop = 0; m_ptr = N - 1;
      return;
    end
    found = 0;
    idx   = 0;
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (!found && m_pend[i]) begin found = 1; idx = i; end
    end
`else
    for (int i = N - 1; i >= 0; i--)
      if (!found && m_pend[i]) begin found = 1; idx = i; end
`endif
    free_s = !m_valid || rdy;
    for (int i = 0; i < N; i++)
      if (e && r[i] && m_pend[i] && !(free_s && found && idx == i)) m_drop = 1;
    if (free_s) begin
      if (found) begin
        m_pend  = m_pend & ~(1 << idx);
        m_valid = 1;
        m_code  = idx;
        m_ptr   = idx;
      end else begin
        m_valid = 0;
        m_code  = 0;
      end
    end
    if (e) m_pend = m_pend | (r & 'hF);
  endtask

  task automatic cyc(input bit e, input logic [3:0] r, input bit rdy, input bit rs);
    en = e; req = r; code_ready = rdy; rst = rs;
    @(posedge clk);
    model_edge(e, int'(r), rdy, rs);
    #1;
    cyc_n++;
    check("code_valid", 32'(code_valid), 32'(m_valid));
    check("code",       32'(code),       32'(m_code));
    check("pending",    32'(pending),    32'(m_pend));
    check("drop_err",   32'(drop_err),   32'(m_drop));
  endtask

  initial begin
    en = 0; req = 0; code_ready = 1; rst = 1;
    m_pend = 0; m_valid = 0; m_code = 0; m_drop = 0; m_ptr = N - 1;

    // Reset state
    cyc(0, 4'b0000, 1, 1);
    cyc(1, 4'b1111, 1, 1);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_valid",   32'(code_valid), 32'h0);

    // Single event latency
    cyc(1, 4'b0100, 1, 0);
    check("lat_pend_k", 32'(pending), 32'h4);
    check("lat_valid_k", 32'(code_valid), 32'h0);
    cyc(0, 4'b0000, 1, 0);
    check("lat_valid_k1", 32'(code_valid), 32'h1);
    check("lat_code_k1", 32'(code), 32'h2);
    cyc(0, 4'b0000, 1, 0);
    check("lat_idle_k2", 32'(code_valid), 32'h0);

    // Selection order for three simultaneous events
    cyc(0, 4'b0000, 1, 1);
    cyc(1, 4'b1011, 1, 0);
    cyc(0, 4'b0000, 1, 0);
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    check("order_1st", 32'(code), 32'h0);
    cyc(0, 4'b0000, 1, 0);
    check("order_2nd", 32'(code), 32'h1);
    cyc(0, 4'b0000, 1, 0);
    check("order_3rd", 32'(code), 32'h3);
`else
    check("order_1st", 32'(code), 32'h3);
    cyc(0, 4'b0000, 1, 0);
    check("order_2nd", 32'(code), 32'h1);
    cyc(0, 4'b0000, 1, 0);
    check("order_3rd", 32'(code), 32'h0);
`endif
    cyc(0, 4'b0000, 1, 0);
    check("order_idle", 32'(code_valid), 32'h0);

    // Backpressure holds the slot
    cyc(1, 4'b0100, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    cyc(1, 4'b0001, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0000, 0, 0);
    check("hold_code", 32'(code), 32'h2);
    check("hold_valid", 32'(code_valid), 32'h1);
    check("hold_pend0", 32'(pending[0]), 32'h1);
    cyc(0, 4'b0000, 1, 0);
    check("after_hold_valid", 32'(code_valid), 32'h1);
    check("after_hold_code", 32'(code), 32'h0);
    cyc(0, 4'b0000, 1, 0);

    // Coalescing sets sticky drop_err
    cyc(1, 4'b0100, 1, 0);
    cyc(1, 4'b0010, 0, 0);
    cyc(1, 4'b0010, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    cyc(1, 4'b0010, 0, 0);
    check("drop_set", 32'(drop_err), 32'h1);
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 1, 0);
    check("drop_sticky", 32'(drop_err), 32'h1);
    cyc(0, 4'b0000, 1, 1);
    check("drop_rst", 32'(drop_err), 32'h0);
    // Event coinciding with its own load is re-queued, not dropped
    cyc(1, 4'b0010, 1, 0);
    cyc(1, 4'b0010, 1, 0);
    check("coinc_code", 32'(code), 32'h1);
    check("coinc_pend1", 32'(pending[1]), 32'h1);
    check("coinc_drop", 32'(drop_err), 32'h0);
    cyc(0, 4'b0000, 1, 0);
    cyc(0, 4'b0000, 1, 0);

    // en=0 ignores req, pending still drains
    cyc(1, 4'b1001, 0, 0);
    cyc(0, 4'b1111, 0, 0);
    check("en0_code", 32'(code), 32'h3);
    cyc(0, 4'b1111, 0, 0);
    check("en0_pend", 32'(pending), 32'h1);
    cyc(0, 4'b1111, 1, 0);
    check("en0_drain", 32'(code), 32'h0);
    cyc(0, 4'b0000, 1, 0);

    // Reset mid-transfer discards everything
    cyc(1, 4'b1110, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    check("pre_rst_valid", 32'(code_valid), 32'h1);
    cyc(0, 4'b0000, 0, 1);
    check("midrst_all", {code_valid, code, pending, drop_err}, 32'h0);
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 1, 0);
    check("midrst_quiet", 32'(code_valid), 32'h0);

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      bit rs_r, e_r, rdy_r;
      logic [3:0] r_r;
      rs_r  = ($urandom_range(0, 63) == 0);
      e_r   = ($urandom_range(0, 3) != 0);
      r_r   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      rdy_r = ($urandom_range(0, 3) != 0);
      cyc(e_r, r_r, rdy_r, rs_r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/event_encoder.md
EVENT_ENCODER -- requirements
Module: event_encoder

Interface
REQ-001 Parameter N, default 4: number of request lines; legal range 2..16.
REQ-002 Parameter W, default $clog2(N): width of code; SHALL be derived from N and not overridden independently.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  capture enable; when 0, req is ignored but queued events still drain.
REQ-006 req  input  N  event lines; bit i high for a cycle posts event i.
REQ-007 code_valid  output  1  code holds a valid event index.
REQ-008 code_ready  input  1  consumer accepts code when code_valid and code_ready are both high on an edge.
REQ-009 code  output  W  binary index of the emitted event.
REQ-010 pending  output  N  events captured but not yet emitted.
REQ-011 drop_err  output  1  sticky: an event was lost by coalescing.

Function
REQ-012 Each edge with en=1 SHALL OR req into pending; bit i of pending clears only when index i is loaded into code.
REQ-013 Output slot is free when code_valid=0 or a transfer (code_valid & code_ready) occurs this edge.
REQ-014 When the slot is free and pending (registered value) is nonzero, the selected index SHALL be loaded into code, code_valid SHALL be set, and that pending bit SHALL be cleared on the same edge.
REQ-015 When the slot is free and pending is zero, code_valid SHALL clear on that edge.
REQ-016 Latency: req high before edge k sets pending at k; code_valid rises at edge k+1 if the slot is free; with code_ready held high, sustained throughput is one code per cycle.
REQ-017 While code_valid=1 and code_ready=0, code and code_valid SHALL hold stable.
REQ-018 Simultaneous set and clear of the same pending bit (req[i] with en=1 in the same cycle that i is loaded) SHALL leave the bit set; the new event is not lost.
REQ-019 req[i] with en=1 while pending[i]=1 and i is not being loaded that edge SHALL set drop_err; drop_err clears only on rst.
REQ-020 Default selection: fixed priority, highest set index wins (e.g. pending=4'b1010 emits 3, then 1).
REQ-021 code SHALL be 0 whenever code_valid=0.

Reset
REQ-022 On an edge with rst=1: pending=0, code_valid=0, code=0, drop_err=0, round-robin pointer=N-1; req is not captured on that edge.
REQ-023 Reset mid-transfer SHALL discard the held code and all pending events with no output handshake.

Configuration
REQ-024 Macro EVENT_ENCODER_ROUND_ROBIN_EN defined: selection is round-robin; the search starts at (last loaded index + 1) mod N, increasing index with wraparound; the pointer updates only on load.
REQ-025 Macro EVENT_ENCODER_ROUND_ROBIN_EN undefined: fixed priority per REQ-020; no pointer register is synthesized.

Structure
REQ-026 Shared package enc_pkg SHALL hold the default N, the max-N constant (16), and the index-width function used to derive W.
REQ-027 One combinational sub-module enc_pick (inputs: pending vector, start index; outputs: found, index) SHALL implement selection; fixed-priority mode passes a constant start.
REQ-028 event_encoder holds all registers: pending, code, code_valid, drop_err, pointer.

Verification
REQ-029 rst, then req=4'b0100 for 1 cycle with en=1, code_ready=1 -> pending=4'b0100 after edge k; code_valid=1 and code=2 after edge k+1; idle after edge k+2.
REQ-030 req=4'b1011 for one cycle with code_ready=1 -> codes 3,1,0 on consecutive cycles (fixed priority); with the macro on and pointer=N-1, codes 0,1,3.
REQ-031 code_valid=1, code=2, code_ready=0 held 5 cycles while req=4'b0001 arrives -> code stays 2; pending[0]=1; after code_ready=1, code=0 follows next cycle.
REQ-032 req[1] pulsed twice while pending[1]=1 and the slot is blocked -> drop_err=1 and stays 1 until rst; a req[1] coinciding with the load of index 1 -> pending[1] remains 1 and drop_err is unaffected.
REQ-033 en=0 with req=4'b1111 -> pending unchanged; queued events still drain.
REQ-034 rst asserted with code_valid=1 and pending=4'b0110 -> next cycle all outputs 0 and no further codes.
